uart_rx_fifo: RTL and testbench

UART receiver stage directly upstream of the picorv_uart core's byte interface. Samples the serial rx line, deserializes 8N1 frames LSB-first at a fixed baud, and buffers received bytes in a small FIFO. Delivers bytes on a ready/valid interface to the core-side consumer. Flags framing errors and FIFO overruns.

---
 rtl/uart_rx_fifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo
//
// UART receive stage feeding a byte-wide ready/valid consumer. The serial
// line is brought into the clock domain by a two-flop synchronizer, 8N1
// frames are deserialized LSB first at a fixed baud, and completed bytes are
// buffered in a small FIFO.
//
// Parameters:
//   ClkFreq   system clock frequency in Hz
//   BaudRate  line rate in bits/s
//   Depth     FIFO entries (power of two, >= 2)
//
// Ports:
//   clk_i        system clock, rising edge
//   reset_i      synchronous active-high reset
//   rx_i         asynchronous serial line, idle high
//   data_o       head-of-FIFO byte (0 while the FIFO is empty)
//   valid_o      FIFO non-empty
//   ready_i      consumer takes data_o when valid_o & ready_i
//   frame_err_o  one-cycle pulse: stop bit sampled low
//   overrun_o    sticky: a completed byte was dropped on a full FIFO
//   clear_i      clears overrun_o (a new overrun on the same edge wins)
// ---------------------------------------------------------------------------
module uart_rx_fifo #(
  parameter int ClkFreq  = 12000000,
  parameter int BaudRate = 115200,
  parameter int Depth    = 4
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  input  logic       clear_i
);

  localparam int ClksPerBit = ClkFreq / BaudRate;
  localparam int HalfBit    = ClksPerBit / 2;
  localparam int CntW       = $clog2(ClksPerBit);
  localparam int AddrW      = $clog2(Depth);

  localparam logic [CntW-1:0] BitEnd  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfEnd = CntW'(HalfBit - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronizer. Both flops reset to the idle (high) line level so a
  // reset never looks like a start bit.
  // -------------------------------------------------------------------------
  logic rx_meta_reg;
  logic rx_s_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_reg <= 1'b1;
      rx_s_reg    <= 1'b1;
    end else begin
      rx_meta_reg <= rx_i;
      rx_s_reg    <= rx_meta_reg;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM: state register
  // -------------------------------------------------------------------------
  state_t          state_reg, state_next;
  logic [CntW-1:0] cnt_reg, cnt_next;
  logic [2:0]      idx_reg, idx_next;
  logic [7:0]      shift_reg, shift_next;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      shift_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      shift_reg <= shift_next;
    end
  end

  // -------------------------------------------------------------------------
  // Receive FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    shift_next = shift_reg;

    unique case (state_reg)
      IDLE: begin
        cnt_next = '0;
        if (!rx_s_reg) begin
          state_next = START;
        end
      end

      START: begin
        // Re-check the line half a bit in; a high level here was a glitch.
        if (cnt_reg == HalfEnd) begin
          cnt_next = '0;
          if (!rx_s_reg) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      DATA: begin
        if (cnt_reg == BitEnd) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s_reg;
          if (idx_reg == 3'd7) begin
            state_next = STOP;
          end else begin
            idx_next = idx_reg + 3'd1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      STOP: begin
        // Leave in the middle of the stop bit so a start bit that follows
        // immediately is still caught on its falling edge.
        if (cnt_reg == BitEnd) begin
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Receive FSM: outputs (decoded from the stop-bit sample point)
  // -------------------------------------------------------------------------
  logic stop_sample;
  logic push_req;
  logic frame_bad;

  always_comb begin
    stop_sample = 1'b0;
    push_req    = 1'b0;
    frame_bad   = 1'b0;
    if (state_reg == STOP && cnt_reg == BitEnd) begin
      stop_sample = 1'b1;
      push_req    = rx_s_reg;
      frame_bad   = !rx_s_reg;
    end
  end

  logic frame_err_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      frame_err_reg <= 1'b0;
    end else begin
      frame_err_reg <= frame_bad;
    end
  end

  // -------------------------------------------------------------------------
  // Byte FIFO. Pointers carry one extra wrap bit so full and empty are
  // distinguishable when the address bits match.
  // -------------------------------------------------------------------------
  logic [7:0]     mem [Depth];
  logic [AddrW:0] wr_ptr_reg;
  logic [AddrW:0] rd_ptr_reg;
  logic           fifo_empty;
  logic           fifo_full;
  logic           pop;
  logic           push_ok;
  logic           drop;

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[AddrW] != rd_ptr_reg[AddrW]) &&
                      (wr_ptr_reg[AddrW-1:0] == rd_ptr_reg[AddrW-1:0]);

  assign pop = !fifo_empty && ready_i;

  // A full FIFO still accepts a byte when the head leaves on the same edge.
  assign push_ok = push_req && (!fifo_full || pop);
  assign drop    = push_req && fifo_full && !pop;

  // Storage has no reset: contents are only visible through valid_o.
  always_ff @(posedge clk_i) begin
    if (push_ok) begin
      mem[wr_ptr_reg[AddrW-1:0]] <= shift_reg;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
    end
  end

  // Sticky overrun; a drop on the same edge as clear_i keeps it set.
  logic overrun_reg;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      overrun_reg <= 1'b0;
    end else if (drop) begin
      overrun_reg <= 1'b1;
    end else if (clear_i) begin
      overrun_reg <= 1'b0;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. data_o is forced to zero while empty so stale storage never
  // leaks onto the bus.
  // -------------------------------------------------------------------------
  assign valid_o     = !fifo_empty;
  assign data_o      = fifo_empty ? 8'h00 : mem[rd_ptr_reg[AddrW-1:0]];
  assign frame_err_o = frame_err_reg;
  assign overrun_o   = overrun_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_fifo
//
// Self-checking bench for uart_rx_fifo at default parameters (104 clocks per
// bit). Frames are driven bit by bit onto rx_i; a negedge monitor collects
// every accepted byte and frame-error pulse, and expectations come from a
// frame/queue-level model of the receiver and FIFO.
// ---------------------------------------------------------------------------
module tb_uart_rx_fifo;

  localparam int BIT   = 12000000 / 115200;  // clocks per bit
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       rx_i;
  logic [7:0] data_o;
  logic       valid_o;
  logic       ready_i;
  logic       frame_err_o;
  logic       overrun_o;
  logic       clear_i;

  uart_rx_fifo #(
    .ClkFreq (12000000),
    .BaudRate(115200),
    .Depth   (DEPTH)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset_i),
    .rx_i       (rx_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .frame_err_o(frame_err_o),
    .overrun_o  (overrun_o),
    .clear_i    (clear_i)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  // Monitor state
  logic [7:0] got_q[$];
  int         ferr_hi = 0;
  int         ferr_rise = 0;
  int         rise_cyc = 0;
  int         ovr_during_clear = 0;
  logic       ferr_prev = 1'b0;
  logic       valid_prev = 1'b0;

  always @(negedge clk) begin
    if (!reset_i) begin
      if (valid_o && ready_i) got_q.push_back(data_o);
      if (frame_err_o) ferr_hi++;
      if (frame_err_o && !ferr_prev) ferr_rise++;
      if (valid_o && !valid_prev) rise_cyc = cyc;
      if (clear_i && overrun_o) ovr_during_clear = 1;
    end
    ferr_prev  = frame_err_o;
    valid_prev = valid_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    ferr_hi          = 0;
    ferr_rise        = 0;
    ovr_during_clear = 0;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    rx_i    = 1'b1;
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx_i = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BIT) tick();
    end
    rx_i = stop_bit;
    repeat (BIT) tick();
    rx_i = 1'b1;
  endtask

  function automatic logic [31:0] got_at(input int i);
    if (i < got_q.size()) return {24'h0, got_q[i]};
    return 32'hDEAD_BEEF;
  endfunction

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int          bad;
    int          start_cyc;
    int          lat;
    logic [7:0]  exp_q[$];
    logic [7:0]  sent_q[$];
    int          nbad;
    int          k;
    int          kept;
    logic [7:0]  b;
    logic        fault;

    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h3C, 1'b0, 0, 1};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h96, 1'b0, 0, 1};
    vecs[5] = '{8'h5A, 1'b1, 1, 0};

    reset_i = 1'b1;
    rx_i    = 1'b1;
    ready_i = 1'b0;
    clear_i = 1'b0;
    do_reset();

    // Reset state and a quiet idle line
    check("rst_valid", {31'h0, valid_o}, 0);
    check("rst_data", {24'h0, data_o}, 0);
    check("rst_ferr", {31'h0, frame_err_o}, 0);
    check("rst_overrun", {31'h0, overrun_o}, 0);
    bad = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (valid_o !== 1'b0 || data_o !== 8'h00 || frame_err_o !== 1'b0 || overrun_o !== 1'b0)
        bad++;
    end
    check("idle_2000_quiet_cycles_bad", bad, 0);

    // Table of single frames, consumer always ready
    ready_i = 1'b1;
    for (int v = 0; v < 6; v++) begin
      clear_mon();
      start_cyc = cyc;
      send_byte(vecs[v].data, vecs[v].stop);
      repeat (200) tick();
      check($sformatf("vec%0d_bytes", v), got_q.size(), vecs[v].exp_bytes);
      if (vecs[v].exp_bytes == 1) check($sformatf("vec%0d_data", v), got_at(0), {24'h0, vecs[v].data});
      check($sformatf("vec%0d_ferr_pulses", v), ferr_rise, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ferr_cycles", v), ferr_hi, vecs[v].exp_ferr);
      check($sformatf("vec%0d_overrun", v), {31'h0, overrun_o}, 0);
      if (v == 0) begin
        lat = rise_cyc - start_cyc;
        check("vec0_latency_near_990", (lat >= 985 && lat <= 995), 1);
      end
    end

    // Four back-to-back bytes held, then drained in order
    clear_mon();
    ready_i = 1'b0;
    send_byte(8'h01, 1'b1);
    send_byte(8'h7F, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h00, 1'b1);
    repeat (50) tick();
    check("b2b_valid_held", {31'h0, valid_o}, 1);
    check("b2b_head", {24'h0, data_o}, 32'h01);
    ready_i = 1'b1;
    repeat (20) tick();
    check("b2b_count", got_q.size(), 4);
    check("b2b_pop0", got_at(0), 32'h01);
    check("b2b_pop1", got_at(1), 32'h7F);
    check("b2b_pop2", got_at(2), 32'hFF);
    check("b2b_pop3", got_at(3), 32'h00);
    check("b2b_valid_drop", {31'h0, valid_o}, 0);

    // Overrun: fifth byte dropped, clear, then set-dominance against clear
    clear_mon();
    ready_i = 1'b0;
    for (int i = 0; i < 5; i++) send_byte(8'h10 + 8'(i), 1'b1);
    repeat (20) tick();
    check("ovr_set", {31'h0, overrun_o}, 1);
    check("ovr_head", {24'h0, data_o}, 32'h10);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    tick();
    check("ovr_cleared", {31'h0, overrun_o}, 0);
    check("ovr_fifo_kept", {31'h0, valid_o}, 1);
    fork
      send_byte(8'h55, 1'b1);
      begin
        repeat (900) tick();
        clear_i = 1'b1;
        repeat (200) tick();
        clear_i = 1'b0;
      end
    join
    check("ovr_set_beats_clear", ovr_during_clear, 1);
    check("ovr_cleared_after", {31'h0, overrun_o}, 0);
    ready_i = 1'b1;
    repeat (20) tick();
    check("ovr_drain_count", got_q.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("ovr_drain%0d", i), got_at(i), 32'h10 + i);
    check("ovr_drain_empty", {31'h0, valid_o}, 0);

    // 30-cycle low glitch on an idle line
    clear_mon();
    rx_i = 1'b0;
    repeat (30) tick();
    rx_i = 1'b1;
    repeat (300) tick();
    check("glitch_bytes", got_q.size(), 0);
    check("glitch_ferr", ferr_rise, 0);
    check("glitch_valid", {31'h0, valid_o}, 0);

    // Reset in the middle of 0x5A's data bits, then a clean 0xC3
    rx_i = 1'b0;
    repeat (BIT) tick();
    for (int i = 0; i < 4; i++) begin
      rx_i = (8'h5A >> i) & 8'h1;
      repeat (BIT) tick();
    end
    do_reset();
    repeat (300) tick();
    send_byte(8'hC3, 1'b1);
    repeat (200) tick();
    check("midrst_count", got_q.size(), 1);
    check("midrst_data", got_at(0), 32'hC3);
    check("midrst_ferr", ferr_rise, 0);

    // Break: line held low for 2500 cycles -> a frame error per frame time
    clear_mon();
    rx_i = 1'b0;
    repeat (2500) tick();
    check("break_ferr_pulses", ferr_rise, 2);
    check("break_ferr_cycles", ferr_hi, 2);
    check("break_bytes", got_q.size(), 0);
    check("break_valid", {31'h0, valid_o}, 0);
    do_reset();
    repeat (200) tick();

    // Random frames with random stop faults and gaps, consumer ready
    clear_mon();
    exp_q.delete();
    nbad = 0;
    ready_i = 1'b1;
    for (int n = 0; n < 10; n++) begin
      b     = 8'($urandom_range(0, 255));
      fault = ($urandom_range(0, 4) == 0);
      send_byte(b, !fault);
      if (fault) nbad++;
      else exp_q.push_back(b);
      repeat (fault ? 200 : $urandom_range(0, 150)) tick();
    end
    repeat (200) tick();
    check("rnd_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) check($sformatf("rnd_byte%0d", i), got_at(i), {24'h0, exp_q[i]});
    check("rnd_ferr_pulses", ferr_rise, nbad);
    check("rnd_ferr_cycles", ferr_hi, nbad);
    check("rnd_overrun", {31'h0, overrun_o}, 0);

    // Random burst sizes against a stalled consumer: FIFO keeps the first DEPTH
    for (int r = 0; r < 3; r++) begin
      clear_mon();
      sent_q.delete();
      ready_i = 1'b0;
      k = $urandom_range(1, 7);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom_range(0, 255));
        sent_q.push_back(b);
        send_byte(b, 1'b1);
      end
      repeat (50) tick();
      kept = (k > DEPTH) ? DEPTH : k;
      check($sformatf("burst%0d_k%0d_overrun", r, k), {31'h0, overrun_o}, (k > DEPTH) ? 1 : 0);
      check($sformatf("burst%0d_head", r), {24'h0, data_o}, {24'h0, sent_q[0]});
      ready_i = 1'b1;
      repeat (20) tick();
      check($sformatf("burst%0d_count", r), got_q.size(), kept);
      for (int i = 0; i < kept; i++) check($sformatf("burst%0d_byte%0d", r, i), got_at(i), {24'h0, sent_q[i]});
      check($sformatf("burst%0d_empty", r), {31'h0, valid_o}, 0);
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
